csr: RTL and testbench
======================

CSR -- requirements
Module: csr

Interface
REQ-001 The module SHALL have parameter WORD_LEN, default 32, meaning the CSR data width; only 32 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port addr, input, 12 bits: CSR address, used for both read and write.
REQ-005 The module SHALL have port rdata, output, WORD_LEN bits: combinational read data of the CSR at addr.
REQ-006 The module SHALL have port wen, input, 1 bit: write enable, high to write wdata to the CSR at addr on the next rising clk.
REQ-007 The module SHALL have port wdata, input, WORD_LEN bits: write data; read-modify-write (set/clear) is formed by the caller.
REQ-008 The module SHALL have port trap_vector, output, WORD_LEN bits: trap target address, {mtvec[31:2], 2'b00}.

Function
REQ-009 Implemented read/write CSRs SHALL be: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343 and mip 0x344.
REQ-010 Implemented read-only CSRs SHALL be: misa 0x301 = 0x40000100 (RV32I), mvendorid 0xF11 = 0, marchid 0xF12 = 0, mimpid 0xF13 = 0 and mhartid 0xF14 = 0.
REQ-011 rdata SHALL be purely combinational from addr and current state, with zero-cycle latency and no dependence on wen.
REQ-012 A write SHALL update the addressed register at the rising clk edge where wen=1; the new value SHALL be visible on rdata in the same cycle after that edge.
REQ-013 While wen=1 and before the edge, rdata SHALL show the old value, so a CSRRW/CSRRS/CSRRC returns the pre-write value.
REQ-014 Writes to read-only or unimplemented addresses SHALL be ignored without error.
REQ-015 Unimplemented addresses SHALL read 0.
REQ-016 mepc[1:0] SHALL always read 0; written low bits are discarded.
REQ-017 mtvec SHALL store all 32 bits, but trap_vector SHALL force bits [1:0] to 0, giving direct mode only.
REQ-018 mstatus SHALL be writable only in bits MIE[3], MPIE[7] and MPP[12:11]; other bits SHALL read 0.
REQ-019 mip SHALL read 0 and ignore writes, since there are no interrupt sources.
REQ-020 When wen=1 with addr 0x342 and wdata = 11, mcause SHALL become 11; no special decoding is applied (ecall cause is supplied by the caller).
REQ-021 trap_vector SHALL be combinational from mtvec and SHALL reflect a write one edge after it.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for clk, clear all writable CSRs to 0, so that trap_vector = 0 and rdata at any writable address = 0.
REQ-023 Reset SHALL override a simultaneous write.
REQ-024 Release of rst_n SHALL take effect at the next clk edge.

Configuration
REQ-025 With macro CSR_COUNTER_EN defined, the module SHALL implement 64-bit counter mcycle (0xB00 low, 0xB80 high), with read-only aliases cycle 0xC00 / cycleh 0xC80.
REQ-026 With CSR_COUNTER_EN defined, mcycle SHALL increment by 1 every clk edge and wrap from 2^64-1 to 0.
REQ-027 With CSR_COUNTER_EN defined, a write to 0xB00/0xB80 SHALL replace that half instead of incrementing that edge, and reset SHALL clear the counter to 0.
REQ-028 Without CSR_COUNTER_EN, those four addresses SHALL behave as unimplemented: read 0, writes ignored.

Verification
REQ-029 Reset: assert rst_n=0 mid-cycle -> trap_vector=0 and rdata(0x305)=0 immediately; rdata(0x301)=0x40000100.
REQ-030 Write then read: wen=1, addr 0x340, wdata 0xDEADBEEF, for one edge -> rdata(0x340)=0xDEADBEEF; before the edge it reads 0.
REQ-031 mtvec: write 0x00000107 -> rdata(0x305)=0x00000107 and trap_vector=0x00000104.
REQ-032 Masking and ignored writes: write 0xFFFFFFFF to mepc -> reads 0xFFFFFFFC; to mstatus -> reads 0x00001888; to 0xF14 and 0x7C0 -> both read 0.
REQ-033 ecall sequence: addr 0x342, wdata 11, wen for one edge -> rdata(0x342)=11; wen=0 for further edges -> value held.
REQ-034 With CSR_COUNTER_EN: after reset release, 10 edges -> rdata(0xC00)=10; write 0xFFFFFFFF to 0xB00 then 1 edge -> low=0 and high=1. Without CSR_COUNTER_EN -> 0xC00 reads 0.

Source files
------------

// File: rtl/csr.sv
// Machine-mode CSR file: combinational read port, single write port, trap vector output.
// Define CSR_COUNTER_EN to add the 64-bit mcycle counter and its cycle/cycleh aliases.
module csr #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11:0]         addr,
  output logic [WORD_LEN-1:0] rdata,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] trap_vector
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMisa      = 12'h301;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMip       = 12'h344;
  localparam logic [11:0] AddrMvendorid = 12'hF11;
  localparam logic [11:0] AddrMarchid   = 12'hF12;
  localparam logic [11:0] AddrMimpid    = 12'hF13;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  localparam logic [WORD_LEN-1:0] MisaValue   = WORD_LEN'(32'h4000_0100);
  // Only MIE[3], MPIE[7] and MPP[12:11] exist in mstatus.
  localparam logic [WORD_LEN-1:0] MstatusMask = WORD_LEN'(32'h0000_1888);
  localparam logic [WORD_LEN-1:0] LowTwoClear = ~WORD_LEN'(3);

  logic [WORD_LEN-1:0] mstatus_q;
  logic [WORD_LEN-1:0] mie_q;
  logic [WORD_LEN-1:0] mtvec_q;
  logic [WORD_LEN-1:0] mscratch_q;
  logic [WORD_LEN-1:0] mepc_q;
  logic [WORD_LEN-1:0] mcause_q;
  logic [WORD_LEN-1:0] mtval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (wen) begin
      case (addr)
        AddrMstatus:  mstatus_q  <= wdata & MstatusMask;
        AddrMie:      mie_q      <= wdata;
        AddrMtvec:    mtvec_q    <= wdata;
        AddrMscratch: mscratch_q <= wdata;
        AddrMepc:     mepc_q     <= wdata & LowTwoClear;
        AddrMcause:   mcause_q   <= wdata;
        AddrMtval:    mtval_q    <= wdata;
        default: ;
      endcase
    end
  end

  assign trap_vector = mtvec_q & LowTwoClear;

`ifdef CSR_COUNTER_EN
  localparam logic [11:0] AddrMcycle  = 12'hB00;
  localparam logic [11:0] AddrMcycleh = 12'hB80;
  localparam logic [11:0] AddrCycle   = 12'hC00;
  localparam logic [11:0] AddrCycleh  = 12'hC80;
  localparam logic [2*WORD_LEN-1:0] CycleOne = (2*WORD_LEN)'(1);

  logic [2*WORD_LEN-1:0] mcycle_q;
  logic [2*WORD_LEN-1:0] mcycle_d;

  // A write to either half replaces it and suppresses that edge's increment.
  always_comb begin
    mcycle_d = mcycle_q + CycleOne;
    if (wen && addr == AddrMcycle) begin
      mcycle_d = {mcycle_q[2*WORD_LEN-1:WORD_LEN], wdata};
    end else if (wen && addr == AddrMcycleh) begin
      mcycle_d = {wdata, mcycle_q[WORD_LEN-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q <= '0;
    end else begin
      mcycle_q <= mcycle_d;
    end
  end
`else
  // No counter: 0xB00/0xB80/0xC00/0xC80 fall through to the unimplemented default.
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      AddrMstatus:   rdata = mstatus_q;
      AddrMisa:      rdata = MisaValue;
      AddrMie:       rdata = mie_q;
      AddrMtvec:     rdata = mtvec_q;
      AddrMscratch:  rdata = mscratch_q;
      AddrMepc:      rdata = mepc_q;
      AddrMcause:    rdata = mcause_q;
      AddrMtval:     rdata = mtval_q;
      AddrMip:       rdata = '0;
      AddrMvendorid: rdata = '0;
      AddrMarchid:   rdata = '0;
      AddrMimpid:    rdata = '0;
      AddrMhartid:   rdata = '0;
`ifdef CSR_COUNTER_EN
      AddrMcycle,  AddrCycle:  rdata = mcycle_q[WORD_LEN-1:0];
      AddrMcycleh, AddrCycleh: rdata = mcycle_q[2*WORD_LEN-1:WORD_LEN];
`endif
      default:       rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_csr.sv
// Directed self-checking bench for the csr block; counter checks follow CSR_COUNTER_EN.
module tb_csr;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] trap_vector;

  int tests;
  int failures;

  csr #(.WORD_LEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .rdata      (rdata),
    .wen        (wen),
    .wdata      (wdata),
    .trap_vector(trap_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write at a negedge, let it land on the next posedge, then sample 1 unit later.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic test_reset();
    do_write(12'h305, 32'h0000_0100);
    do_write(12'h340, 32'h0000_0005);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    addr  = 12'h305;
    #1;
    tests++;
    if (trap_vector !== 32'h0) begin
      failures++;
      $display("FAIL reset_trap_vector: got %h expected %h", trap_vector, 32'h0);
    end
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mtvec: got %h expected %h", rdata, 32'h0);
    end
    addr = 12'h340;
    #1;
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mscratch: got %h expected %h", rdata, 32'h0);
    end
    addr = 12'h301;
    #1;
    tests++;
    if (rdata !== 32'h4000_0100) begin
      failures++;
      $display("FAIL reset_misa: got %h expected %h", rdata, 32'h4000_0100);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    addr  = 12'h340;
    wdata = 32'hDEAD_BEEF;
    wen   = 1'b1;
    #1;
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL pre_write_old_value: got %h expected %h", rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    wen = 1'b0;
    tests++;
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mscratch_write: got %h expected %h", rdata, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_mtvec();
    do_write(12'h305, 32'h0000_0107);
    tests++;
    if (rdata !== 32'h0000_0107) begin
      failures++;
      $display("FAIL mtvec_read: got %h expected %h", rdata, 32'h0000_0107);
    end
    tests++;
    if (trap_vector !== 32'h0000_0104) begin
      failures++;
      $display("FAIL trap_vector: got %h expected %h", trap_vector, 32'h0000_0104);
    end
  endtask

  task automatic test_masking();
    logic [11:0] addrs [6];
    logic [31:0] exp   [6];
    addrs = '{12'h341, 12'h300, 12'hF14, 12'h7C0, 12'h344, 12'h301};
    exp   = '{32'hFFFF_FFFC, 32'h0000_1888, 32'h0, 32'h0, 32'h0, 32'h4000_0100};
    for (int i = 0; i < 6; i++) begin
      do_write(addrs[i], 32'hFFFF_FFFF);
      tests++;
      if (rdata !== exp[i]) begin
        failures++;
        $display("FAIL mask_addr_%h: got %h expected %h", addrs[i], rdata, exp[i]);
      end
    end
  endtask

  task automatic test_ecall();
    do_write(12'h342, 32'd11);
    tests++;
    if (rdata !== 32'd11) begin
      failures++;
      $display("FAIL mcause_write: got %h expected %h", rdata, 32'd11);
    end
    @(negedge clk);
    wdata = 32'h0000_0055;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rdata !== 32'd11) begin
      failures++;
      $display("FAIL mcause_hold: got %h expected %h", rdata, 32'd11);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    addr  = 12'h304;
    wdata = 32'h0000_A5A5;
    wen   = 1'b1;
    @(negedge clk);
    addr  = 12'h343;
    wdata = 32'h1234_5678;
    @(negedge clk);
    wen  = 1'b0;
    addr = 12'h304;
    #1;
    tests++;
    if (rdata !== 32'h0000_A5A5) begin
      failures++;
      $display("FAIL b2b_mie: got %h expected %h", rdata, 32'h0000_A5A5);
    end
    addr = 12'h343;
    #1;
    tests++;
    if (rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL b2b_mtval: got %h expected %h", rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_reset_overrides_write();
    @(negedge clk);
    addr  = 12'h340;
    wdata = 32'h0BAD_F00D;
    wen   = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_over_write: got %h expected %h", rdata, 32'h0);
    end
    @(negedge clk);
    wen   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_counter();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    addr = 12'hC00;
    #1;
`ifdef CSR_COUNTER_EN
    tests++;
    if (rdata !== 32'd10) begin
      failures++;
      $display("FAIL cycle_count: got %h expected %h", rdata, 32'd10);
    end
    do_write(12'hB00, 32'hFFFF_FFFF);
    tests++;
    if (rdata !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL mcycle_write: got %h expected %h", rdata, 32'hFFFF_FFFF);
    end
    @(posedge clk);
    #1;
    addr = 12'hC00;
    #1;
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL cycle_wrap_low: got %h expected %h", rdata, 32'h0);
    end
    addr = 12'hC80;
    #1;
    tests++;
    if (rdata !== 32'h1) begin
      failures++;
      $display("FAIL cycle_carry_high: got %h expected %h", rdata, 32'h1);
    end
`else
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL cycle_absent: got %h expected %h", rdata, 32'h0);
    end
    do_write(12'hB00, 32'hFFFF_FFFF);
    tests++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL mcycle_absent_write: got %h expected %h", rdata, 32'h0);
    end
`endif
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    wen      = 1'b0;
    addr     = 12'h0;
    wdata    = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_write_read();
    test_mtvec();
    test_masking();
    test_ecall();
    test_back_to_back();
    test_reset_overrides_write();
    test_counter();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
